sram_pio_bridge: RTL and testbench

- Sits between the Nios PIO ports and the board's external 16-bit asynchronous SRAM (256K x 16).
- The data PIO out_port supplies write data, and its in_port receives read data. Address and control PIOs supply a word address and a go/read-not-write handshake.
- The block turns each 32-bit CPU request into two sequenced 16-bit SRAM accesses (low half first) and reports busy/done back to software.

---
 rtl/sram_pio_bridge.sv | 167 ++++++++++++++++
 tb/tb_sram_pio_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pio_bridge.sv
// Bridges Nios PIO ports to a 16-bit asynchronous SRAM: each 32-bit request
// becomes two registered-strobe SRAM accesses, low halfword first.
module sram_pio_bridge #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cpu_wdata,
  input  logic [ADDR_W-2:0] cpu_addr,
  input  logic              cpu_go,
  input  logic              cpu_rnw,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int WCW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic              half_reg, half_next;
  logic [WCW-1:0]    wait_reg, wait_next;
  logic              go_q_reg;
  logic [ADDR_W-2:0] addr_reg, addr_next;
  logic              rnw_reg, rnw_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       shadow_reg, shadow_next;
  logic [31:0]       rdata_reg, rdata_next;

  logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
  logic [15:0]       dq_out_reg, dq_out_next;
  logic              dq_oe_reg, dq_oe_next;
  logic              ce_n_reg, ce_n_next;
  logic              oe_n_reg, oe_n_next;
  logic              we_n_reg, we_n_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              active_next;

  always_comb begin
    state_next  = state_reg;
    half_next   = half_reg;
    wait_next   = wait_reg;
    addr_next   = addr_reg;
    rnw_next    = rnw_reg;
    wdata_next  = wdata_reg;
    shadow_next = shadow_reg;
    rdata_next  = rdata_reg;

    case (state_reg)
      S_IDLE: begin
        if (cpu_go && !go_q_reg) begin
          state_next = S_SETUP;
          half_next  = 1'b0;
          addr_next  = cpu_addr;
          rnw_next   = cpu_rnw;
          wdata_next = cpu_wdata;
        end
      end
      S_SETUP: begin
        state_next = S_ACCESS;
        wait_next  = '0;
      end
      S_ACCESS: begin
        if (wait_reg == WCW'(WAIT_CYCLES)) begin
          state_next = S_HOLD;
          // Sample on the edge that closes the strobe window
          if (rnw_reg) begin
            if (half_reg) shadow_next[31:16] = sram_dq_in;
            else          shadow_next[15:0]  = sram_dq_in;
          end
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_HOLD: begin
        if (half_reg) begin
          state_next = S_DONE;
          if (rnw_reg) rdata_next = shadow_reg;
        end else begin
          half_next  = 1'b1;
          state_next = S_SETUP;
        end
      end
      S_DONE: begin
        if (!cpu_go) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Pin-facing outputs are decoded from the next state so they register cleanly
    active_next    = (state_next == S_SETUP) || (state_next == S_ACCESS) ||
                     (state_next == S_HOLD);
    ce_n_next      = !active_next;
    we_n_next      = !((state_next == S_ACCESS) && !rnw_next);
    oe_n_next      = !(rnw_next && ((state_next == S_SETUP) || (state_next == S_ACCESS)));
    dq_oe_next     = active_next && !rnw_next;
    sram_addr_next = {addr_next, half_next};
    dq_out_next    = half_next ? wdata_next[31:16] : wdata_next[15:0];
    busy_next      = active_next;
    done_next      = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      half_reg      <= 1'b0;
      wait_reg      <= '0;
      go_q_reg      <= 1'b1;
      addr_reg      <= '0;
      rnw_reg       <= 1'b0;
      wdata_reg     <= '0;
      shadow_reg    <= '0;
      rdata_reg     <= '0;
      sram_addr_reg <= '0;
      dq_out_reg    <= '0;
      dq_oe_reg     <= 1'b0;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      half_reg      <= half_next;
      wait_reg      <= wait_next;
      go_q_reg      <= cpu_go;
      addr_reg      <= addr_next;
      rnw_reg       <= rnw_next;
      wdata_reg     <= wdata_next;
      shadow_reg    <= shadow_next;
      rdata_reg     <= rdata_next;
      sram_addr_reg <= sram_addr_next;
      dq_out_reg    <= dq_out_next;
      dq_oe_reg     <= dq_oe_next;
      ce_n_reg      <= ce_n_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign cpu_rdata   = rdata_reg;
  assign cpu_busy    = busy_reg;
  assign cpu_done    = done_reg;
  assign sram_addr   = sram_addr_reg;
  assign sram_dq_out = dq_out_reg;
  assign sram_dq_oe  = dq_oe_reg;
  assign sram_ce_n   = ce_n_reg;
  assign sram_oe_n   = oe_n_reg;
  assign sram_we_n   = we_n_reg;
  assign sram_ub_n   = ce_n_reg;
  assign sram_lb_n   = ce_n_reg;

endmodule

// File: tb/tb_sram_pio_bridge.sv
// Drives two bridges (WAIT_CYCLES 1 and 3) with shared PIO stimulus and checks
// every cycle against a timeline model plus a few hand-computed expectations.
module tb_sram_pio_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cpu_wdata;
  logic [16:0] cpu_addr;
  logic        cpu_go;
  logic        cpu_rnw;

  logic [31:0] rdata_w [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [17:0] saddr_w [2];
  logic [15:0] dqo_w   [2];
  logic [15:0] dqi_w   [2];
  logic        dqoe_w  [2];
  logic        ce_w    [2];
  logic        oen_w   [2];
  logic        wen_w   [2];
  logic        ub_w    [2];
  logic        lb_w    [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cyc [2];
  int we_low   [2];
  int oe_low   [2];
  logic [16:0] wq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int W   = (gi == 0) ? 1 : 3;
      localparam int PER = W + 3;

      sram_pio_bridge #(.ADDR_W(18), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_wdata(cpu_wdata), .cpu_addr(cpu_addr), .cpu_go(cpu_go), .cpu_rnw(cpu_rnw),
        .cpu_rdata(rdata_w[gi]), .cpu_busy(busy_w[gi]), .cpu_done(done_w[gi]),
        .sram_addr(saddr_w[gi]), .sram_dq_out(dqo_w[gi]), .sram_dq_oe(dqoe_w[gi]),
        .sram_dq_in(dqi_w[gi]), .sram_ce_n(ce_w[gi]), .sram_oe_n(oen_w[gi]),
        .sram_we_n(wen_w[gi]), .sram_ub_n(ub_w[gi]), .sram_lb_n(lb_w[gi])
      );

      // Asynchronous SRAM device
      bit [15:0] dev_mem [0:262143];
      always @(posedge clk) if (!ce_w[gi] && !wen_w[gi]) dev_mem[saddr_w[gi]] <= dqo_w[gi];
      assign dqi_w[gi] = (!ce_w[gi] && !oen_w[gi]) ? dev_mem[saddr_w[gi]] : 16'h0000;

      // Reference: cycles elapsed since the accepted go edge define the phase
      bit          m_active = 1'b0, m_done = 1'b0, m_goq = 1'b1, m_rnw = 1'b0;
      int          m_t = 0;
      logic [16:0] m_addr = '0;
      logic [31:0] m_wd = '0, m_rdata = '0;
      bit   [15:0] ref_mem [int];
      int          k0, k1, h, p;
      logic        e_we, e_oe;

      always @(posedge clk) begin
        if (!reset_n) begin
          m_active = 0; m_done = 0; m_goq = 1; m_rdata = '0; m_t = 0;
        end else begin
          if (m_active) begin
            m_t++;
            if (m_t == 2 * PER) begin
              m_active = 0;
              m_done   = 1;
              k0 = int'({m_addr, 1'b0});
              k1 = int'({m_addr, 1'b1});
              if (m_rnw) begin
                m_rdata[15:0]  = ref_mem.exists(k0) ? ref_mem[k0] : 16'h0;
                m_rdata[31:16] = ref_mem.exists(k1) ? ref_mem[k1] : 16'h0;
              end else begin
                ref_mem[k0] = m_wd[15:0];
                ref_mem[k1] = m_wd[31:16];
              end
            end
          end else if (m_done) begin
            if (!cpu_go) m_done = 0;
          end else if (cpu_go && !m_goq) begin
            m_active = 1; m_t = 0; m_addr = cpu_addr; m_rnw = cpu_rnw; m_wd = cpu_wdata;
          end
          m_goq = cpu_go;
        end
      end

      always @(negedge clk) begin
        if (m_active) begin
          h    = m_t / PER;
          p    = m_t % PER;
          e_we = !(!m_rnw && p >= 1 && p <= W + 1);
          e_oe = !(m_rnw && p <= W + 1);
          chk($sformatf("i%0d_busy", gi), busy_w[gi], 1);
          chk($sformatf("i%0d_ce_n", gi), ce_w[gi], 0);
          chk($sformatf("i%0d_we_n", gi), wen_w[gi], e_we);
          chk($sformatf("i%0d_oe_n", gi), oen_w[gi], e_oe);
          chk($sformatf("i%0d_dq_oe", gi), dqoe_w[gi], !m_rnw);
          chk($sformatf("i%0d_sram_addr", gi), saddr_w[gi], {m_addr, h[0]});
          if (!m_rnw)
            chk($sformatf("i%0d_dq_out", gi), dqo_w[gi], h[0] ? m_wd[31:16] : m_wd[15:0]);
        end else begin
          chk($sformatf("i%0d_busy", gi), busy_w[gi], 0);
          chk($sformatf("i%0d_ce_n", gi), ce_w[gi], 1);
          chk($sformatf("i%0d_we_n", gi), wen_w[gi], 1);
          chk($sformatf("i%0d_oe_n", gi), oen_w[gi], 1);
          chk($sformatf("i%0d_dq_oe", gi), dqoe_w[gi], 0);
        end
        chk($sformatf("i%0d_ub_lb", gi), {ub_w[gi], lb_w[gi]}, {2{ce_w[gi]}});
        chk($sformatf("i%0d_done", gi), done_w[gi], m_done);
        chk($sformatf("i%0d_rdata", gi), rdata_w[gi], m_rdata);
        chk($sformatf("i%0d_busy_done_excl", gi), busy_w[gi] & done_w[gi], 0);
        if (done_w[gi] && done_cyc[gi] < 0) done_cyc[gi] = cyc;
        if (!wen_w[gi]) we_low[gi]++;
        if (!oen_w[gi]) oe_low[gi]++;
      end
    end
  endgenerate

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int start_cyc;

  task automatic start_txn(input logic [16:0] a, input logic [31:0] wd, input logic rnw);
    cpu_addr = a; cpu_wdata = wd; cpu_rnw = rnw;
    for (int i = 0; i < 2; i++) begin
      done_cyc[i] = -1; we_low[i] = 0; oe_low[i] = 0;
    end
    cpu_go    = 1'b1;
    start_cyc = cyc + 1;
    tick(1);
    // Scramble the PIOs once the request has been taken
    cpu_addr = 17'($urandom); cpu_wdata = $urandom; cpu_rnw = 1'($urandom);
  endtask

  task automatic wait_done();
    int budget = 60;
    while ((done_cyc[0] < 0 || done_cyc[1] < 0) && budget > 0) begin
      tick(1);
      budget--;
    end
    chk("done_seen", {31'b0, (done_cyc[0] >= 0) && (done_cyc[1] >= 0)}, 1);
  endtask

  task automatic do_txn(input logic [16:0] a, input logic [31:0] wd, input logic rnw,
                        input int hold_after);
    start_txn(a, wd, rnw);
    wait_done();
    tick(hold_after);
    cpu_go = 1'b0;
    tick(2);
  endtask

  initial begin
    int we_before;
    reset_n = 1'b0; cpu_go = 1'b1; cpu_rnw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_strobes", {ce_w[0], oen_w[0], wen_w[0], ub_w[0], lb_w[0]}, 5'b11111);
    chk("rst_dq_oe", dqoe_w[0], 0);
    chk("rst_rdata", rdata_w[0], 32'h0);
    chk("rst_sram_addr", saddr_w[0], 18'h0);
    chk("rst_dq_out", dqo_w[0], 16'h0);
    cpu_go = 1'b0;
    tick(1);

    // Write then read back
    do_txn(17'h00010, 32'hDEADBEEF, 1'b0, 0);
    chk("wr_done_lat_w1", done_cyc[0] - start_cyc, 8);
    chk("wr_done_lat_w3", done_cyc[1] - start_cyc, 12);
    chk("wr_we_low_w1", we_low[0], 4);
    chk("wr_we_low_w3", we_low[1], 8);
    chk("wr_mem_lo", g_inst[0].dev_mem[18'h00020], 16'hBEEF);
    chk("wr_mem_hi", g_inst[0].dev_mem[18'h00021], 16'hDEAD);
    wq.push_back(17'h00010);
    do_txn(17'h00010, 32'h0, 1'b1, 0);
    chk("rd_oe_low_w1", oe_low[0], 6);
    chk("rd_oe_low_w3", oe_low[1], 10);
    chk("rd_rdata_w1", rdata_w[0], 32'hDEADBEEF);
    chk("rd_rdata_w3", rdata_w[1], 32'hDEADBEEF);

    // Go held after done, address changed mid-transaction
    start_txn(17'h0ABCD, 32'hCAFEF00D, 1'b0);
    tick(1);
    cpu_addr = 17'h15555;
    wait_done();
    we_before = we_low[0];
    tick(5);
    chk("hs_no_retrigger", we_low[0] - we_before, 0);
    chk("hs_done_held", done_w[0], 1);
    cpu_go = 1'b0;
    tick(1);
    chk("hs_idle_after_drop", done_w[0], 0);
    chk("hs_mem_lo", g_inst[0].dev_mem[18'h1579A], 16'hF00D);
    chk("hs_mem_hi", g_inst[0].dev_mem[18'h1579B], 16'hCAFE);
    wq.push_back(17'h0ABCD);
    do_txn(17'h0ABCD, 32'h0, 1'b1, 1);
    chk("hs_rdata", rdata_w[0], 32'hCAFEF00D);

    // Reset while the strobe is asserted
    start_txn(17'h00077, 32'h11112222, 1'b0);
    tick(1);
    chk("abort_in_access", wen_w[0], 0);
    reset_n = 1'b0;
    tick(1);
    chk("abort_we_n", {wen_w[0], wen_w[1]}, 2'b11);
    chk("abort_dq_oe", {dqoe_w[0], dqoe_w[1]}, 2'b00);
    chk("abort_busy", {busy_w[0], busy_w[1]}, 2'b00);
    reset_n = 1'b1;
    cpu_go  = 1'b0;
    tick(2);
    do_txn(17'h00033, 32'hA5A55A5A, 1'b0, 0);
    wq.push_back(17'h00033);
    do_txn(17'h00033, 32'h0, 1'b1, 0);
    chk("post_abort_rdata", rdata_w[0], 32'hA5A55A5A);

    // Top of the address range
    do_txn(17'h1FFFF, 32'h12345678, 1'b0, 0);
    chk("top_done_lat_w3", done_cyc[1] - start_cyc, 12);
    chk("top_we_low_w3", we_low[1], 8);
    chk("top_mem_lo", g_inst[1].dev_mem[18'h3FFFE], 16'h5678);
    chk("top_mem_hi", g_inst[1].dev_mem[18'h3FFFF], 16'h1234);
    wq.push_back(17'h1FFFF);

    // Random traffic, including go pulses that fall before done
    for (int i = 0; i < 40; i++) begin
      logic        rd;
      logic [16:0] a;
      logic [31:0] wd;
      rd = (wq.size() > 0) && ($urandom_range(0, 1) == 1);
      a  = rd ? wq[$urandom_range(0, wq.size() - 1)] : 17'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        start_txn(a, wd, rd);
        tick($urandom_range(0, 2));
        cpu_go = 1'b0;
        wait_done();
        tick(2);
      end else begin
        do_txn(a, wd, rd, $urandom_range(0, 3));
      end
      if (!rd) wq.push_back(a);
      tick($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
